ps2_scancode_rx: RTL and testbench

- Upstream stage of the text-console writer.
- Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data pins and validates framing and odd parity.
- Translates each scancode-set-2 byte into the 10-bit console code the writer consumes, presented with a one-cycle done strobe.
- Every received byte is emitted, including the byte after a break prefix, because the writer discards that byte itself.

---
 rtl/ps2_scancode_rx.sv | 168 ++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver. It synchronises and filters the raw pins, checks framing and odd parity,
// and translates each scancode-set-2 byte into the 10-bit console code used by the text writer.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] teclado,
  output logic       done,
  output logic       frame_err
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_OUT} state_t;

  state_t                state_q, state_d;
  logic [1:0]            clk_sync_q, clk_sync_d;
  logic [1:0]            data_sync_q, data_sync_d;
  logic [FILTER_LEN-1:0] filt_sr_q, filt_sr_d;
  logic                  filt_q, filt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  par_q, par_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [9:0]            teclado_q, teclado_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  sample_evt;
  logic                  bit_in;

  function automatic logic [9:0] xlate(input logic [7:0] b);
    logic [9:0] code;
    case (b)
      8'hF0: code = 10'h0F0;
      8'h5A: code = 10'h0C0;
      8'h66: code = 10'h108;
      8'h29: code = 10'd0;
      8'h1C: code = 10'd1;   8'h32: code = 10'd2;   8'h21: code = 10'd3;
      8'h23: code = 10'd4;   8'h24: code = 10'd5;   8'h2B: code = 10'd6;
      8'h34: code = 10'd7;   8'h33: code = 10'd8;   8'h43: code = 10'd9;
      8'h3B: code = 10'd10;  8'h42: code = 10'd11;  8'h4B: code = 10'd12;
      8'h3A: code = 10'd13;  8'h31: code = 10'd14;  8'h44: code = 10'd15;
      8'h4D: code = 10'd16;  8'h15: code = 10'd17;  8'h2D: code = 10'd18;
      8'h1B: code = 10'd19;  8'h2C: code = 10'd20;  8'h3C: code = 10'd21;
      8'h2A: code = 10'd22;  8'h1D: code = 10'd23;  8'h22: code = 10'd24;
      8'h35: code = 10'd25;  8'h1A: code = 10'd26;
      8'h45: code = 10'd27;  8'h16: code = 10'd28;  8'h1E: code = 10'd29;
      8'h26: code = 10'd30;  8'h25: code = 10'd31;  8'h2E: code = 10'd32;
      8'h36: code = 10'd33;  8'h3D: code = 10'd34;  8'h3E: code = 10'd35;
      8'h46: code = 10'd36;
      default: code = {2'b10, b};
    endcase
    return code;
  endfunction

  // The filter sees a clean 1->0 edge only when every stored sample agrees; that cycle is the event.
  assign sample_evt = filt_q && (filt_sr_q == '0);
  assign bit_in     = data_sync_q[1];

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned (no latch).
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_sr_d   = {filt_sr_q[FILTER_LEN-2:0], clk_sync_q[1]};
    filt_d      = filt_q;
    if (filt_sr_q == '1)      filt_d = 1'b1;
    else if (filt_sr_q == '0) filt_d = 1'b0;

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    teclado_d = teclado_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (sample_evt) begin
          if (!bit_in) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DATA, S_PARITY, S_STOP: begin
        if (sample_evt) begin
          tmo_d = '0;
          case (state_q)
            S_DATA: begin
              shift_d   = {bit_in, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
              par_d   = bit_in;
              state_d = S_STOP;
            end
            default: begin
              // The output is loaded on the stop event so teclado and done appear together in OUT.
              if (bit_in && (^{shift_q, par_q})) begin
                teclado_d = xlate(shift_q);
                done_d    = 1'b1;
                state_d   = S_OUT;
              end else begin
                err_d   = 1'b1;
                state_d = S_IDLE;
              end
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_sr_q   <= '1;
      filt_q      <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      teclado_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_sr_q   <= filt_sr_d;
      filt_q      <= filt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      teclado_q   <= teclado_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign teclado   = teclado_q;
  assign done      = done_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: directed scenarios plus random frames against a
// table-driven reference translation.
module tb_ps2_scancode_rx;

  localparam int FILTER_LEN = 8;
  localparam int TMO        = 3000;
  localparam int HALF       = 20;

  localparam logic [7:0] LETTERS [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
    8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  typedef struct {
    logic [1:0] kind;   // 2'b10 = done, 2'b01 = frame_err
    logic [9:0] code;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [9:0] teclado;
  logic       done;
  logic       frame_err;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [9:0] held = '0;
  logic prev_strobe = 1'b0;

  ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .teclado(teclado), .done(done), .frame_err(frame_err));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] model(input logic [7:0] b);
    if (b == 8'hF0) return 10'h0F0;
    if (b == 8'h5A) return 10'h0C0;
    if (b == 8'h66) return 10'h108;
    if (b == 8'h29) return 10'd0;
    for (int i = 0; i < 26; i++) if (LETTERS[i] == b) return 10'(i + 1);
    for (int i = 0; i < 10; i++) if (DIGITS[i] == b) return 10'(i + 27);
    return 10'h200 | 10'(b);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cycles(5);
    ps2_clk = 1'b0;
    cycles(HALF);
    ps2_clk = 1'b1;
    cycles(HALF);
  endtask

  task automatic push(input logic [1:0] kind, input logic [9:0] code);
    exp_t e;
    e.kind = kind;
    e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop_bit);
    if (!flip_par && stop_bit) push(2'b10, model(b));
    else                       push(2'b01, 10'd0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip_par);
    send_bit(stop_bit);
    ps2_data = 1'b1;
    cycles(10 + int'($urandom_range(0, 40)));
  endtask

  // Monitor: every strobe is matched against the head of the expectation queue.
  always @(negedge clk) begin
    if (rst) begin
      held        = '0;
      prev_strobe = 1'b0;
    end else begin
      if (done || frame_err) begin
        check("strobe_not_back_to_back", {31'd0, prev_strobe}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {30'd0, done, frame_err}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_kind", {30'd0, done, frame_err}, {30'd0, e.kind});
          if (e.kind == 2'b10) check("teclado", {22'd0, teclado}, {22'd0, e.code});
        end
        if (done) held = teclado;
      end else begin
        check("teclado_hold", {22'd0, teclado}, {22'd0, held});
      end
      prev_strobe = done || frame_err;
    end
  end

  initial begin
    logic [7:0] b;
    int         mode;
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cycles(5);
    check("reset_teclado", {22'd0, teclado}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    cycles(20);

    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    send_frame(8'h45, 1'b1, 1'b1);
    send_frame(8'h45, 1'b0, 1'b1);

    // Glitch one cycle shorter than the filter: must be invisible.
    ps2_clk = 1'b0;
    cycles(FILTER_LEN - 1);
    ps2_clk = 1'b1;
    cycles(40);

    send_frame(8'h29, 1'b0, 1'b0);

    // Start bit sampled high in IDLE.
    push(2'b01, 10'd0);
    send_bit(1'b1);
    cycles(20);

    // Truncated frame left idle until the timeout fires.
    push(2'b01, 10'd0);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    cycles(TMO + 200);
    send_frame(8'h66, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);

    // Reset mid-frame drops the partial byte silently.
    b = 8'h1A;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(b[i]);
    ps2_data = 1'b1;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(20);
    send_frame(8'h1A, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       b = LETTERS[$urandom_range(0, 25)];
        1:       b = DIGITS[$urandom_range(0, 9)];
        default: b = 8'($urandom_range(0, 255));
      endcase
      mode = int'($urandom_range(0, 19));
      send_frame(b, mode < 2, mode != 2);
    end

    cycles(50);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
